// File: rtl/vec_lsu.sv
// Strided vector load/store unit: issues up to MAXLEN elements as 4-lane beats with padded scatter and gathered loads.
// Optional address bounds check is built when VEC_LSU_BOUNDS_CHECK_EN is defined.
module vec_lsu #(
    parameter int MAXLEN     = 16,
    parameter int ADDR_LIMIT = 1001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [31:0] req_base,
    input  logic [31:0] req_stride,
    input  logic [4:0]  req_len,
    input  logic [31:0] req_wdata  [0:MAXLEN-1],
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata [0:MAXLEN-1],
    output logic        resp_err,
    output logic [31:0] mem_va     [0:3],
    output logic [31:0] mem_wdv    [0:3],
    output logic        mem_wev,
    input  logic [31:0] mem_rdv    [0:3]
);
    localparam int EW = $clog2(MAXLEN);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, next_state;

    logic        store_r, req_ready_r, resp_valid_r, wev_r;
    logic [31:0] base_r, stride_r, len_r, e0_r;
    logic [31:0] wdata_r [0:MAXLEN-1];
    logic [31:0] rbuf_r  [0:MAXLEN-1];
    logic [31:0] va_r    [0:3];
    logic [31:0] wdv_r   [0:3];

    logic        accept_s, nxt_has_s, nxt_oob_s, nxt_go_s;
    logic [31:0] eff_len_s, src_base_s, src_stride_s, src_len_s, nxt_e0_s, nact_s;
    logic [31:0] lane_e_s  [0:3];
    logic [31:0] nxt_va_s  [0:3];
    logic [31:0] nxt_wdv_s [0:3];

    assign accept_s  = (state == IDLE) && req_valid;
    assign eff_len_s = ({27'd0, req_len} > 32'(MAXLEN)) ? 32'(MAXLEN) : {27'd0, req_len};

    // Build the next beat: beat 0 straight from the request when idle, else the beat after the current one.
    always_comb begin
        src_base_s   = base_r;
        src_stride_s = stride_r;
        src_len_s    = len_r;
        nxt_e0_s     = e0_r + 32'd4;
        if (state == IDLE) begin
            src_base_s   = req_base;
            src_stride_s = req_stride;
            src_len_s    = eff_len_s;
            nxt_e0_s     = 32'd0;
        end else begin
            src_base_s   = base_r;
        end
        nxt_has_s = (nxt_e0_s < src_len_s);
        nact_s    = ((src_len_s - nxt_e0_s) > 32'd4) ? 32'd4 : (src_len_s - nxt_e0_s);
        nxt_oob_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // Inactive lanes replay the highest active lane so padded writes are harmless.
            lane_e_s[i]  = nxt_e0_s + ((32'(i) < nact_s) ? 32'(i) : (nact_s - 32'd1));
            nxt_va_s[i]  = src_base_s + lane_e_s[i] * src_stride_s;
            nxt_wdv_s[i] = 32'd0;
            if (lane_e_s[i] < 32'(MAXLEN)) begin
                nxt_wdv_s[i] = (state == IDLE) ? req_wdata[lane_e_s[i][EW-1:0]]
                                               : wdata_r[lane_e_s[i][EW-1:0]];
            end else begin
                nxt_wdv_s[i] = 32'd0;
            end
`ifdef VEC_LSU_BOUNDS_CHECK_EN
            if (nxt_va_s[i] >= 32'(ADDR_LIMIT)) begin
                nxt_oob_s = 1'b1;
            end else begin
                nxt_oob_s = nxt_oob_s;
            end
`endif
        end
        nxt_go_s = nxt_has_s && !nxt_oob_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = nxt_go_s ? ACCESS : RESP;
                end else begin
                    next_state = IDLE;
                end
            end
            ACCESS: next_state = nxt_go_s ? ACCESS : RESP;
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end else begin
                    next_state = RESP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, registered beat outputs, load gather and handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            store_r      <= 1'b0;
            base_r       <= 32'd0;
            stride_r     <= 32'd0;
            len_r        <= 32'd0;
            e0_r         <= 32'd0;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            wev_r        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                va_r[i]  <= 32'd0;
                wdv_r[i] <= 32'd0;
            end
            for (int m = 0; m < MAXLEN; m++) begin
                wdata_r[m] <= 32'd0;
                rbuf_r[m]  <= 32'd0;
            end
        end else begin
            req_ready_r  <= (next_state == IDLE);
            resp_valid_r <= (next_state == RESP);
            if (next_state == ACCESS) begin
                for (int i = 0; i < 4; i++) begin
                    va_r[i]  <= nxt_va_s[i];
                    wdv_r[i] <= nxt_wdv_s[i];
                end
                wev_r <= (state == IDLE) ? req_store : store_r;
                e0_r  <= nxt_e0_s;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    va_r[i]  <= 32'd0;
                    wdv_r[i] <= 32'd0;
                end
                wev_r <= 1'b0;
            end
            if (accept_s) begin
                store_r  <= req_store;
                base_r   <= req_base;
                stride_r <= req_stride;
                len_r    <= eff_len_s;
                for (int m = 0; m < MAXLEN; m++) begin
                    wdata_r[m] <= req_wdata[m];
                    rbuf_r[m]  <= 32'd0;
                end
            end else if (state == ACCESS && !store_r) begin
                for (int i = 0; i < 4; i++) begin
                    if ((e0_r + 32'(i)) < len_r) begin
                        rbuf_r[e0_r[EW-1:0] + EW'(i)] <= mem_rdv[i];
                    end
                end
            end
        end
    end

`ifdef VEC_LSU_BOUNDS_CHECK_EN
    logic err_r;

    // Error flag: set when the beat about to issue fails, cleared on accept and on response completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (state == IDLE || state == ACCESS) begin
            err_r <= (next_state == RESP) && nxt_has_s && nxt_oob_s;
        end else if (resp_ready) begin
            err_r <= 1'b0;
        end
    end

    assign resp_err = err_r;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = rbuf_r;
    assign mem_va     = va_r;
    assign mem_wdv    = wdv_r;
    // Reset kills a write in flight without waiting for the next edge.
    assign mem_wev    = wev_r & ~reset;
endmodule

// File: doc/vec_lsu.md
# vec_lsu

Vector load/store unit that drives the data memory's 4-lane vector port from the CPU execute stage. It accepts a strided vector memory request of up to MAXLEN 32-bit elements and issues it as back-to-back 4-lane beats. Loads are gathered into a result buffer; stores are scattered with lane padding, so that lanes past the vector length are never written. A completion response is returned to the pipeline through a valid/ready handshake.

## Interface
- MAXLEN, 16: maximum elements per request; multiple of 4.
- ADDR_LIMIT, 1001: number of valid memory words, used only by the bounds check.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  unit idle and able to accept.
- req_store  in  1  1 = store, 0 = load.
- req_base  in  32  word address of element 0.
- req_stride  in  32  word stride between elements, two's complement.
- req_len  in  5  element count; 0 allowed; values above MAXLEN saturate to MAXLEN.
- req_wdata[0:MAXLEN-1]  in  32 each  store data, element-indexed.
- resp_valid  out  1  request complete.
- resp_ready  in  1  pipeline accepts the response.
- resp_rdata[0:MAXLEN-1]  out  32 each  load result; all zero for stores.
- resp_err  out  1  bounds violation (see Configuration).
- mem_va[0:3]  out  32 each  lane addresses to memory.
- mem_wdv[0:3]  out  32 each  lane write data.
- mem_wev  out  1  vector write enable.
- mem_rdv[0:3]  in  32 each  lane read data; combinational from mem_va.

## Operation
- FSM states:
  - IDLE: req_ready=1. Transitions to ACCESS on req_valid, or to RESP if the effective length is 0.
  - ACCESS: one beat per cycle for B = ceil(len/4) beats, then RESP.
  - RESP: resp_valid=1, held with all response outputs stable until resp_ready. Returns to IDLE on the cycle resp_ready is seen.
- On accept:
  - Latch store, base, stride, effective length and wdata.
  - Clear the result buffer and the error flag.
  - Reset the beat counter k to 0.
- Element e address is req_base + e*req_stride, mod 2^32. The multiply is truncated to 32 bits and there is no overflow detection.
- Beat k, lane i handles element e = 4k+i. A lane is active when e < len.
- Padding: an inactive lane copies the address and write data of the highest active lane in that beat. Padded writes rewrite the same word with the same value, so no word outside the vector is touched.
- Stores:
  - mem_wev=1 for every ACCESS beat.
  - mem_wdv[i] = latched wdata[e].
  - When two active lanes alias the same address, memory resolves the conflict and the highest lane wins. This is architecturally defined.
- Loads:
  - mem_wev=0.
  - For active lanes, mem_rdv[i] is captured into buffer[e] at the end of the beat cycle.
  - Buffer entries with e >= len stay 0.
- Outside ACCESS: mem_wev=0 and mem_va, mem_wdv are driven to 0.
- The unit does not accept a new request while in ACCESS or RESP.

## Timing
- Reset values: req_ready=0 while reset is high and 1 in the first cycle after. resp_valid=0, resp_err=0, resp_rdata all 0, mem_wev=0, mem_va and mem_wdv all 0. The FSM is in IDLE.
- Reset mid-operation aborts immediately:
  - No further mem_wev.
  - Beats already written are not undone.
  - The pending response is discarded.
- Accept edge is T0. Beats drive memory in cycles T0+1 .. T0+B, with outputs registered from FSM state. resp_valid rises at T0+B+1.
- A zero-length request raises resp_valid at T0+1.
- If resp_ready is already high when resp_valid rises, the response completes in that cycle and req_ready=1 in the next cycle. Minimum request-to-request spacing is B+2 cycles.
- req_valid asserted while req_ready=0 is ignored. Requestors hold the request until a handshake occurs.

## Configuration
- Macro: VEC_LSU_BOUNDS_CHECK_EN.
- Defined:
  - Each beat checks its active-lane addresses against ADDR_LIMIT; any address >= ADDR_LIMIT fails the beat.
  - On the first failing beat: mem_wev=0 for that whole beat, no load capture, and the FSM moves to RESP with resp_err=1.
  - Earlier beats remain committed.
  - Elements of the failing and subsequent beats read as 0.
- Undefined: no check is performed, resp_err is tied to 0, and addresses pass through unmodified.

## Test plan
- Load, base=10, stride=1, len=8, memory[n]=n+0x100 → two beats, mem_va beat0=10..13 and beat1=14..17; resp_rdata[0..7]=0x10A..0x111, [8..15]=0; resp_valid at T0+3.
- Store, base=100, stride=3, len=6, wdata[e]=0xA0+e → beat1 lanes 2,3 padded to address 115 with data 0xA5; memory 100,103,...,115 updated, 118 and 121 untouched.
- Store, stride=0, base=50, len=4, wdata=1,2,3,4 → memory[50]=4; resp_err=0.
- len=0 → no mem_wev pulse, resp_valid at T0+1, resp_rdata all 0; with resp_ready held low for 5 cycles, the response stays stable and req_ready stays 0.
- Reset asserted during beat 2 of a 4-beat store → beats 0–1 written, no further mem_wev, all outputs at reset values the next cycle, req_ready=1 after release.
- With VEC_LSU_BOUNDS_CHECK_EN: store, base=996, stride=1, len=8 → beat0 (996..999) written, beat1 (1000..1003) suppressed, resp_err=1 at T0+2; without the macro, a load with base=990, len=4 gives resp_err=0.
